// File: rtl/booth_mul_4b.sv
// Sequential 4x4 signed multiplier using radix-2 Booth recoding over a shared 4-bit add/sub unit.
// One product every 10 cycles: IDLE, four ADD/SHIFT pairs, then a one-cycle DONE.
`timescale 1ns/1ps
module booth_mul_4b (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       START,
  input  logic [3:0] MCAND,
  input  logic [3:0] MPLIER,
  output logic [7:0] P,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {StIdle, StAdd, StShift, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] q_q, q_d;
  logic [3:0] m_q, m_d;
  logic       q1_q, q1_d;
  logic       s_q, s_d;
  logic [1:0] cnt_q, cnt_d;

  logic       au_sel;
  logic [3:0] au_f;
  logic       au_v;

  // 4-bit add/subtract unit: F = A + M or A - M, V = signed overflow.
  always_comb begin
    au_sel = (state_q == StAdd) && ({q_q[0], q1_q} == 2'b10);
    au_f   = au_sel ? (a_q - m_q) : (a_q + m_q);
    if (au_sel) begin
      au_v = (a_q[3] != m_q[3]) && (au_f[3] != a_q[3]);
    end else begin
      au_v = (a_q[3] == m_q[3]) && (au_f[3] != a_q[3]);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    q1_d    = q1_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StAdd;
          m_d     = MCAND;
          q_d     = MPLIER;
          a_d     = 4'h0;
          q1_d    = 1'b0;
          s_d     = 1'b0;
          cnt_d   = 2'd0;
        end
      end
      StAdd: begin
        state_d = StShift;
        if (q_q[0] != q1_q) begin
          a_d = au_f;
          // F[3]^V is the true sign of the 5-bit result, which keeps M = -8 exact.
          s_d = au_f[3] ^ au_v;
        end else begin
          s_d = a_q[3];
        end
      end
      StShift: begin
        a_d     = {s_q, a_q[3:1]};
        q_d     = {a_q[0], q_q[3:1]};
        q1_d    = q_q[0];
        cnt_d   = cnt_q + 2'd1;
        state_d = (cnt_q == 2'd3) ? StDone : StAdd;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= StIdle;
      a_q     <= 4'h0;
      q_q     <= 4'h0;
      m_q     <= 4'h0;
      q1_q    <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      q1_q    <= q1_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign P    = {a_q, q_q};
  assign BUSY = (state_q != StIdle);
  assign DONE = (state_q == StDone);

endmodule

// File: tb/tb_booth_mul_4b.sv
// Self-checking bench for booth_mul_4b: directed corners, handshake, reset abort, exhaustive and
// randomized products checked against plain signed arithmetic.
`timescale 1ns/1ps
module tb_booth_mul_4b;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] mcand;
  logic [3:0] mplier;
  logic [7:0] p;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  booth_mul_4b dut (
    .CLK    (clk),
    .RSTn   (rst_n),
    .START  (start),
    .MCAND  (mcand),
    .MPLIER (mplier),
    .P      (p),
    .BUSY   (busy),
    .DONE   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_mul(input logic [3:0] m, input logic [3:0] q);
    int prod;
    prod = int'($signed(m)) * int'($signed(q));
    return prod[7:0];
  endfunction

  // One full transaction; with scramble set, operands and START are randomized while busy.
  task automatic run_mul(input logic [3:0] m, input logic [3:0] q, input bit scramble);
    logic [7:0] exp;
    logic [8:0] r;
    exp = ref_mul(m, q);
    @(negedge clk);
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    @(posedge clk);
    #1;
    check_eq("busy_e0", {31'd0, busy}, 32'd1);
    check_eq("done_e0", {31'd0, done}, 32'd0);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (scramble) begin
        r      = 9'($urandom);
        mcand  = r[3:0];
        mplier = r[7:4];
        start  = r[8];
      end
      @(posedge clk);
      #1;
      if (k == 7) check_eq("done_early", {31'd0, done}, 32'd0);
    end
    start = 1'b0;
    check_eq("done_e8", {31'd0, done}, 32'd1);
    check_eq("busy_e8", {31'd0, busy}, 32'd1);
    check_eq("prod", {24'd0, p}, {24'd0, exp});
    @(posedge clk);
    #1;
    check_eq("busy_e9", {31'd0, busy}, 32'd0);
    check_eq("done_e9", {31'd0, done}, 32'd0);
    check_eq("prod_hold", {24'd0, p}, {24'd0, exp});
  endtask

  initial begin
    int last_done;
    int n_done;

    rst_n  = 1'b1;
    start  = 1'b0;
    mcand  = 4'h0;
    mplier = 4'h0;
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_p", {24'd0, p}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check_eq("idle_p", {24'd0, p}, 32'd0);
      check_eq("idle_busy", {31'd0, busy}, 32'd0);
      check_eq("idle_done", {31'd0, done}, 32'd0);
    end

    run_mul(4'd3, 4'd5, 1'b0);
    run_mul(4'd3, 4'hE, 1'b0);
    run_mul(4'h9, 4'h9, 1'b0);
    run_mul(4'h8, 4'd7, 1'b0);
    run_mul(4'h8, 4'h8, 1'b0);

    // START held high: back-to-back products, DONE pulses 10 cycles apart.
    @(negedge clk);
    mcand     = 4'd2;
    mplier    = 4'd3;
    start     = 1'b1;
    last_done = -1;
    n_done    = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        check_eq("hs_prod", {24'd0, p}, 32'h06);
        if (last_done < 0) check_eq("hs_first", c, 8);
        else check_eq("hs_gap", c - last_done, 10);
        last_done = c;
        n_done++;
      end
    end
    start = 1'b0;
    check_eq("hs_count", n_done, 3);
    @(posedge clk);
    #1;
    check_eq("hs_idle", {31'd0, busy}, 32'd0);

    // Abort with reset at E5.
    @(negedge clk);
    mcand  = 4'd5;
    mplier = 4'hD;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_p", {24'd0, p}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check_eq("abort_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_mul(4'd7, 4'd7, 1'b0);

    for (int i = 0; i < 256; i++) begin
      logic [7:0] pair;
      pair = 8'(i);
      run_mul(pair[3:0], pair[7:4], 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [7:0] r;
      r = 8'($urandom);
      run_mul(r[3:0], r[7:4], 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
